// File: rtl/keypad_shuffle_sequencer_if.sv
// Handshake bundle between control/keypad side and the shuffle sequencer.
// master = control unit side, slave = sequencer.
interface keypad_shuffle_sequencer_if #(
    parameter int NUM_KEYS = 10,
    parameter int KEY_W    = 4
);
    logic                      shuffle_init_i;
    logic [31:0]               seed_i;
    logic                      raw_valid_i;
    logic [KEY_W-1:0]          raw_key_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      digit_valid_o;
    logic [KEY_W-1:0]          digit_o;
    logic                      key_err_o;
    logic [NUM_KEYS*KEY_W-1:0] perm_flat_o;

    modport master (
        output shuffle_init_i, seed_i, raw_valid_i, raw_key_i,
        input  busy_o, done_o, digit_valid_o, digit_o, key_err_o,
        input  perm_flat_o
    );

    modport slave (
        input  shuffle_init_i, seed_i, raw_valid_i, raw_key_i,
        output busy_o, done_o, digit_valid_o, digit_o, key_err_o,
        output perm_flat_o
    );
endinterface

// File: rtl/keypad_shuffle_sequencer.sv
// Keypad scramble: Fisher-Yates shuffle of the key->digit map, one swap
// per clock, plus registered key translation through the current map.
module keypad_shuffle_sequencer #(
    parameter int          NUM_KEYS  = 10,
    parameter int          KEY_W     = 4,
    parameter logic [31:0] LFSR_TAPS = 32'h80200003,
    parameter logic [31:0] ZERO_SEED = 32'h1D872B41
) (
    input logic                    clk_i,
    input logic                    nreset_i,
    keypad_shuffle_sequencer_if.slave bus
);
    localparam int               PW   = 16 + KEY_W + 1;
    localparam logic [KEY_W-1:0] LAST = KEY_W'(NUM_KEYS - 1);
    localparam logic [KEY_W-1:0] ONE  = KEY_W'(1);

    typedef enum logic [1:0] {IDLE, SWAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_next;
    logic [KEY_W-1:0] idx_q;
    logic [KEY_W-1:0] perm_q [NUM_KEYS];
    logic [KEY_W:0]   idx_p1;
    logic [PW-1:0]    prod;
    logic [KEY_W-1:0] j;
    logic [KEY_W-1:0] perm_idx, perm_j, perm_key;
    logic             dv_q, err_q;
    logic [KEY_W-1:0] digit_q;
    logic             init;

    assign init      = bus.shuffle_init_i;
    assign idx_p1    = {1'b0, idx_q} + {{KEY_W{1'b0}}, 1'b1};
    assign prod      = PW'(lfsr_q[15:0]) * PW'(idx_p1);
    assign j         = prod[16 +: KEY_W];
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS)
                                 : (lfsr_q >> 1);

    // Mux reads through compares so an out-of-range key never indexes perm_q.
    always_comb begin
        perm_idx = '0;
        perm_j   = '0;
        perm_key = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (KEY_W'(k) == idx_q)         perm_idx = perm_q[k];
            if (KEY_W'(k) == j)             perm_j   = perm_q[k];
            if (KEY_W'(k) == bus.raw_key_i) perm_key = perm_q[k];
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (init) state_d = SWAP;
            SWAP:    if (init) state_d = SWAP;
                     else if (idx_q == ONE) state_d = DONE;
            DONE:    state_d = init ? SWAP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            lfsr_q  <= ZERO_SEED;
            idx_q   <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            digit_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) perm_q[k] <= KEY_W'(k);
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            if (init) begin
                // Restart keeps the current map; only the walk restarts.
                lfsr_q <= (bus.seed_i == 32'd0) ? ZERO_SEED : bus.seed_i;
                idx_q  <= LAST;
            end else if (state_q == SWAP) begin
                lfsr_q <= lfsr_next;
                idx_q  <= idx_q - ONE;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (KEY_W'(k) == idx_q)  perm_q[k] <= perm_j;
                    else if (KEY_W'(k) == j) perm_q[k] <= perm_idx;
                end
            end else if (state_q == IDLE && bus.raw_valid_i) begin
                if (bus.raw_key_i <= LAST) begin
                    dv_q    <= 1'b1;
                    digit_q <= perm_key;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.perm_flat_o = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            bus.perm_flat_o[k*KEY_W +: KEY_W] = perm_q[k];
    end

    assign bus.busy_o        = (state_q != IDLE);
    assign bus.done_o        = (state_q == DONE);
    assign bus.digit_valid_o = dv_q;
    assign bus.key_err_o     = err_q;
    assign bus.digit_o       = digit_q;
endmodule
